bist_ctrl_fsm: RTL and testbench

- On-chip BIST sequencer for the chip wrapper around the 35-PI / 49-PO circuit under test (CUT).
- Controls the test-pattern generator (TPG LFSR), the PI source mux and the output MISR.
- Counts applied patterns, compares the final MISR signature with a golden constant, and drives the chip-level bistdone/bistpass pins.
- The TPG and MISR are external; this block only sequences them.

---
 rtl/bist_pkg.sv | 62 ++++++
 rtl/bist_pat_cnt.sv | 27 ++
 rtl/bist_ctrl_fsm.sv | 117 +++++++++++
 tb/tb_bist_ctrl_fsm.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding, CUT widths and output decode for the BIST sequencer
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } bist_state_t;

    localparam int CUT_PI_W = 35;
    localparam int CUT_PO_W = 49;

    localparam logic [CUT_PO_W-1:0] DEFAULT_GOLDEN_SIG = '0;

    typedef struct packed {
        logic tpg_seed_load;
        logic tpg_en;
        logic misr_clr;
        logic misr_en;
        logic pi_sel;
        logic cut_rst;
        logic bistdone;
        logic bistpass;
    } bist_outs_t;

    // CHECK keeps pi_sel high so the CUT never sees the chip pins between FLUSH and DONE.
    function automatic bist_outs_t state_outs(input bist_state_t s, input logic pass);
        bist_outs_t o;
        o = '0;
        case (s)
            INIT: begin
                o.tpg_seed_load = 1'b1;
                o.misr_clr      = 1'b1;
                o.cut_rst       = 1'b1;
                o.pi_sel        = 1'b1;
            end
            RUN: begin
                o.tpg_en  = 1'b1;
                o.misr_en = 1'b1;
                o.pi_sel  = 1'b1;
            end
            FLUSH: begin
                o.misr_en = 1'b1;
                o.pi_sel  = 1'b1;
            end
            CHECK: begin
                o.pi_sel = 1'b1;
            end
            DONE: begin
                o.bistdone = 1'b1;
                o.bistpass = pass;
                o.pi_sel   = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/bist_pat_cnt.sv
// rtl/bist_pat_cnt.sv - applied-pattern counter with terminal count at NUM_PATTERNS-1
module bist_pat_cnt #(
    parameter int CNT_W        = 16,
    parameter int NUM_PATTERNS = 2000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CNT_W'(NUM_PATTERNS - 1));

endmodule

// File: rtl/bist_ctrl_fsm.sv
// rtl/bist_ctrl_fsm.sv - BIST sequencer for TPG/MISR/PI mux; BIST_SIG_OUT_EN adds sig_captured
module bist_ctrl_fsm
    import bist_pkg::*;
#(
    parameter int               NUM_PATTERNS = 2000,
    parameter int               CNT_W        = 16,
    parameter int               SIG_W        = CUT_PO_W,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = SIG_W'(DEFAULT_GOLDEN_SIG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bistmode,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             tpg_seed_load,
    output logic             tpg_en,
    output logic             misr_clr,
    output logic             misr_en,
    output logic             pi_sel,
    output logic             cut_rst,
    output logic [CNT_W-1:0] pat_count,
    output logic             bistdone,
    output logic             bistpass
`ifdef BIST_SIG_OUT_EN
    ,
    output logic [SIG_W-1:0] sig_captured
`endif
);

    if (NUM_PATTERNS < 1 || NUM_PATTERNS > (2 ** CNT_W) - 1) begin : g_bad_num_patterns
        $error("bist_ctrl_fsm: NUM_PATTERNS must lie in 1..2**CNT_W-1");
    end

    bist_state_t state_q, state_d;
    logic        pass_q, pass_d;
    bist_outs_t  outs_q, outs_d;
    logic        cnt_clr, cnt_en, cnt_tc;

    // Dropping bistmode anywhere before DONE aborts straight to IDLE without a verdict.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bistmode) state_d = INIT;
            INIT:    state_d = bistmode ? RUN : IDLE;
            RUN: begin
                if (!bistmode)   state_d = IDLE;
                else if (cnt_tc) state_d = FLUSH;
            end
            FLUSH:   state_d = bistmode ? CHECK : IDLE;
            CHECK:   state_d = bistmode ? DONE : IDLE;
            DONE:    if (!bistmode) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pass_d = pass_q;
        if (state_d == IDLE) begin
            pass_d = 1'b0;
        end else if (state_q == CHECK) begin
            pass_d = (misr_sig == GOLDEN_SIG);
        end
    end

    // Outputs are registered from the next state so they line up with the state they decode.
    assign outs_d = state_outs(state_d, pass_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            outs_q  <= outs_d;
        end
    end

    assign cnt_clr = (state_d == IDLE) || (state_d == INIT);
    assign cnt_en  = (state_q == RUN) && (state_d != IDLE);

    bist_pat_cnt #(
        .CNT_W        (CNT_W),
        .NUM_PATTERNS (NUM_PATTERNS)
    ) u_pat_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (pat_count),
        .tc_o  (cnt_tc)
    );

    assign tpg_seed_load = outs_q.tpg_seed_load;
    assign tpg_en        = outs_q.tpg_en;
    assign misr_clr      = outs_q.misr_clr;
    assign misr_en       = outs_q.misr_en;
    assign pi_sel        = outs_q.pi_sel;
    assign cut_rst       = outs_q.cut_rst;
    assign bistdone      = outs_q.bistdone;
    assign bistpass      = outs_q.bistpass;

`ifdef BIST_SIG_OUT_EN
    logic [SIG_W-1:0] sig_q;

    always_ff @(posedge clk) begin
        if (rst || state_d == INIT) begin
            sig_q <= '0;
        end else if (state_q == CHECK) begin
            sig_q <= misr_sig;
        end
    end

    assign sig_captured = sig_q;
`endif

endmodule

// File: tb/tb_bist_ctrl_fsm.sv
// tb/tb_bist_ctrl_fsm.sv - randomized self-checking bench for bist_ctrl_fsm against a run-phase model
module tb_bist_ctrl_fsm;

    localparam int N  = 8;
    localparam int CW = 16;
    localparam int SW = 49;
    localparam logic [SW-1:0] GOLD = 49'h1_2345_6789_ABCD;

    logic          clk = 1'b0;
    logic          rst;
    logic          bistmode;
    logic [SW-1:0] misr_sig;
    logic          tpg_seed_load, tpg_en, misr_clr, misr_en, pi_sel, cut_rst;
    logic [CW-1:0] pat_count;
    logic          bistdone, bistpass;
`ifdef BIST_SIG_OUT_EN
    logic [SW-1:0] sig_captured;
`endif

    always #5 clk = ~clk;

    bist_ctrl_fsm #(
        .NUM_PATTERNS (N),
        .CNT_W        (CW),
        .SIG_W        (SW),
        .GOLDEN_SIG   (GOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bistmode      (bistmode),
        .misr_sig      (misr_sig),
        .tpg_seed_load (tpg_seed_load),
        .tpg_en        (tpg_en),
        .misr_clr      (misr_clr),
        .misr_en       (misr_en),
        .pi_sel        (pi_sel),
        .cut_rst       (cut_rst),
        .pat_count     (pat_count),
        .bistdone      (bistdone),
        .bistpass      (bistpass)
`ifdef BIST_SIG_OUT_EN
        ,
        .sig_captured  (sig_captured)
`endif
    );

    int tests_run  = 0;
    int fail_count = 0;

    // Model: a run is "active" from the edge IDLE sees bistmode=1; m_k counts edges since then.
    bit            m_active = 1'b0;
    int            m_k      = 0;
    bit            m_pass   = 1'b0;
    logic [SW-1:0] m_sig    = '0;

    int tpg_seen, seed_seen, done_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] bad_sig();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return GOLD ^ {r[SW-1:1], 1'b1};
    endfunction

    function automatic logic [7:0] exp_outs();
        if (!m_active)         return 8'b0000_0000;
        if (m_k == 0)          return 8'b1010_1100;
        if (m_k <= N)          return 8'b0101_1000;
        if (m_k == N + 1)      return 8'b0001_1000;
        if (m_k == N + 2)      return 8'b0000_1000;
        return {6'b0000_10, 1'b1, m_pass};
    endfunction

    function automatic logic [CW-1:0] exp_count();
        if (!m_active || m_k == 0) return '0;
        if (m_k <= N)              return CW'(m_k - 1);
        return CW'(N);
    endfunction

    task automatic model_edge(input logic r, input logic bm, input logic [SW-1:0] ms);
        if (r) begin
            m_active = 1'b0;
            m_k      = 0;
            m_pass   = 1'b0;
            m_sig    = '0;
        end else if (!m_active) begin
            if (bm) begin
                m_active = 1'b1;
                m_k      = 0;
                m_sig    = '0;
            end
        end else begin
            if (m_k == N + 2) begin
                m_sig  = ms;
                m_pass = (ms == GOLD);
            end
            if (!bm) begin
                m_active = 1'b0;
                m_pass   = 1'b0;
            end else if (m_k < N + 3) begin
                m_k++;
            end
        end
    endtask

    task automatic step(input logic r, input logic bm, input logic [SW-1:0] ms);
        rst      = r;
        bistmode = bm;
        misr_sig = ms;
        @(posedge clk);
        model_edge(r, bm, ms);
        #1;
        check("outs", {tpg_seed_load, tpg_en, misr_clr, misr_en, pi_sel, cut_rst, bistdone, bistpass},
              exp_outs());
        check("pat_count", pat_count, exp_count());
`ifdef BIST_SIG_OUT_EN
        check("sig_captured", sig_captured, m_sig);
`endif
        if (tpg_en)        tpg_seen++;
        if (tpg_seed_load) seed_seen++;
        if (bistdone)      done_seen++;
    endtask

    task automatic run_once(input bit match);
        logic [SW-1:0] ms;
        int            e;
        ms = match ? GOLD : bad_sig();
        step(1'b1, 1'b1, ms);
        tpg_seen  = 0;
        seed_seen = 0;
        step(1'b0, 1'b1, ms);
        e = 0;
        while (!bistdone && e < 100) begin
            step(1'b0, 1'b1, ms);
            e++;
        end
        check("latency", e, N + 3);
        check("run_pass", bistpass, match);
        check("tpg_cycles", tpg_seen, N);
        check("init_cycles", seed_seen, 1);
        check("final_count", pat_count, N);
        step(1'b0, 1'b1, ms);
        check("done_hold", bistdone, 1'b1);
        step(1'b0, 1'b0, ms);
        check("done_fall", bistdone, 1'b0);
        check("pass_fall", bistpass, 1'b0);
    endtask

    initial begin
        // reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
        check("reset_count", pat_count, '0);

        // fault-free and mismatched single runs
        run_once(1'b1);
        run_once(1'b0);

        // abort at RUN cycle 4, then a full rerun
        step(1'b1, 1'b1, GOLD);
        step(1'b0, 1'b1, GOLD);
        done_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, GOLD);
        step(1'b0, 1'b0, GOLD);
        check("abort_idle_pi_sel", pi_sel, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, GOLD);
        check("abort_no_done", done_seen, 0);
        run_once(1'b1);

        // reset in FLUSH, then rst held with bistmode=1
        step(1'b1, 1'b1, GOLD);
        step(1'b0, 1'b1, GOLD);
        for (int i = 0; i < N + 1; i++) step(1'b0, 1'b1, GOLD);
        step(1'b1, 1'b1, GOLD);
        check("rst_flush_count", pat_count, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, GOLD);
        check("rst_hold_idle", tpg_seed_load, 1'b0);
        step(1'b0, 1'b1, GOLD);
        check("init_after_rst", tpg_seed_load, 1'b1);
        for (int i = 0; i < N + 5; i++) step(1'b0, 1'b1, GOLD);

        // back-to-back campaign with alternating verdicts
        for (int run = 0; run < 11; run++) run_once(run % 2 == 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic          r, bm;
            logic [SW-1:0] ms;
            r  = ($urandom_range(99) < 2);
            bm = ($urandom_range(99) < 96);
            ms = ($urandom_range(1) == 1) ? GOLD : bad_sig();
            step(r, bm, ms);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
